// File: rtl/bexkat1_memory_pkg.sv
// bexkat1Def: instruction types, memory-stage state, access sizes and slot classification
package bexkat1Def;
  localparam logic [3:0] T_INH = 4'h0, T_PUSH = 4'h1, T_POP = 4'h2, T_CMP = 4'h3, T_MOV = 4'h4,
                         T_FPU = 4'h5, T_FP = 4'h6, T_ALU = 4'h7, T_INT = 4'h8, T_LDI = 4'h9,
                         T_LOAD = 4'ha, T_STORE = 4'hb, T_BRANCH = 4'hc, T_JUMP = 4'hd;
  typedef enum logic [1:0] {IDLE, BUS1, BUS2} memstate_t;
  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_t;
  typedef enum logic [2:0] {K_NONE, K_LOAD, K_STORE, K_PUSH, K_POP, K_EXC, K_RST} kind_t;
  typedef struct packed {
    logic [63:0] ir;
    logic [31:0] pc;
    logic        pc_set;
    logic [31:0] result;
    logic [31:0] reg_data2;
    logic [1:0]  reg_write;
    logic [1:0]  sp_write;
    logic [31:0] sp_data;
    logic        halt;
  } slot_t;
  function automatic size_t to_size(logic [1:0] op);
    return op == 2'd1 ? SZ_HALF : op == 2'd2 ? SZ_BYTE : SZ_WORD;
  endfunction
  // interrupt/trap outranks whatever access the instruction itself would make
  function automatic kind_t classify(logic [3:0] t, logic [3:0] op, logic size, logic exc);
    return (exc || (t == T_INH && op == 4'd1 && !size)) ? K_EXC :
           (t == T_INH && op == 4'd5) ? K_RST :
           t == T_LOAD ? K_LOAD : t == T_STORE ? K_STORE :
           t == T_PUSH ? K_PUSH : t == T_POP ? K_POP : K_NONE;
  endfunction
endpackage

// File: rtl/bexkat1_memory_if.sv
// bexkat1_memory_if: Wishbone-classic data bus between the memory stage and memory
interface bexkat1_memory_if;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [31:0] bus_adr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i;
  logic        bus_ack_i;
  modport master (output bus_cyc_o, bus_stb_o, bus_we_o, bus_adr_o, bus_sel_o, bus_dat_o,
                  input bus_dat_i, bus_ack_i);
  modport slave (input bus_cyc_o, bus_stb_o, bus_we_o, bus_adr_o, bus_sel_o, bus_dat_o,
                 output bus_dat_i, bus_ack_i);
endinterface

// File: rtl/bexkat1_memory_bus_lanes.sv
// bus_lanes: big-endian byte-lane select, write replication and zero-extended read extraction
module bus_lanes
  import bexkat1Def::*;
(
  input  logic [1:0]  addr,
  input  size_t       size,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wword,
  output logic [31:0] rval
);
  logic [7:0] rbyte;
  always_comb begin
    sel = size == SZ_BYTE ? 4'b1000 >> addr : size == SZ_HALF ? (addr[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    wword = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    rbyte = addr == 2'd0 ? rdata[31:24] : addr == 2'd1 ? rdata[23:16] : addr == 2'd2 ? rdata[15:8] : rdata[7:0];
    rval = size == SZ_BYTE ? {24'h0, rbyte} :
           size == SZ_HALF ? {16'h0, addr[1] ? rdata[15:0] : rdata[31:16]} : rdata;
  end
endmodule

// File: rtl/bexkat1_memory.sv
// bexkat1_memory: pipeline memory stage running loads, stores, stack and vector traffic on Wishbone
module bexkat1_memory
  import bexkat1Def::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  bexkat1_memory_if.master       bus,
  input  logic [63:0]            ir_i,
  input  logic [31:0]            pc_i,
  input  logic                   pc_set_i,
  input  logic [31:0]            result_i,
  input  logic [31:0]            reg_data2_i,
  input  logic [1:0]             reg_write_i,
  input  logic [1:0]             sp_write_i,
  input  logic [31:0]            sp_data_i,
  input  logic                   exc_i,
  input  logic                   halt_i,
  output logic [63:0]            ir_o,
  output logic [31:0]            pc_o,
  output logic                   pc_set_o,
  output logic [31:0]            result_o,
  output logic [1:0]             reg_write_o,
  output logic [1:0]             sp_write_o,
  output logic [31:0]            sp_data_o,
  output logic                   halt_o,
  output logic                   stall_o
);
  memstate_t state, state_n;
  kind_t kind, kind_in;
  slot_t l;
  logic cyc, cyc_n, mem_start, done, wr, jmp, ret, vec;
  logic [31:0] addr, wsrc, wword, rval;
  logic [3:0] sel;
  size_t size;
  assign kind_in = classify(ir_i[31:28], ir_i[27:24], ir_i[0], exc_i);
  assign mem_start = rst_i && state == IDLE && kind_in != K_NONE;
  assign done = state != IDLE && cyc && bus.bus_ack_i && (state == BUS2 || kind != K_EXC);
  assign stall_o = mem_start || (state != IDLE && !done);
  assign jmp = kind == K_PUSH && l.ir[27:24] != 4'd0;
  assign ret = kind == K_POP && l.ir[27:24] != 4'd0;
  assign vec = kind == K_EXC || kind == K_RST;
  always_comb begin
    wr = state == BUS1 && kind inside {K_STORE, K_PUSH, K_EXC};
    addr = state == BUS2 ? l.result : kind == K_POP ? l.sp_data - 32'd4 :
           (kind == K_PUSH || kind == K_EXC) ? l.sp_data : l.result;
    wsrc = (kind == K_EXC || jmp) ? l.pc : l.reg_data2;
    size = (kind == K_LOAD || kind == K_STORE) ? to_size(l.ir[25:24]) : SZ_WORD;
  end
  bus_lanes lanes (.addr(addr[1:0]), .size(size), .wdata(wsrc), .rdata(bus.bus_dat_i),
                   .sel(sel), .wword(wword), .rval(rval));
  assign bus.bus_cyc_o = cyc;
  assign bus.bus_stb_o = cyc;
  assign bus.bus_we_o  = cyc && wr;
  assign bus.bus_adr_o = cyc ? {addr[31:2], 2'b00} : 32'h0;
  assign bus.bus_sel_o = cyc ? sel : 4'h0;
  assign bus.bus_dat_o = (cyc && wr) ? wword : 32'h0;
  // BUS2 is entered with cyc low, giving the one-cycle gap between exception transactions
  always_comb begin
    state_n = state;
    cyc_n = cyc;
    if (mem_start) begin
      state_n = kind_in == K_RST ? BUS2 : BUS1;
      cyc_n = 1'b1;
    end else if (state == BUS2 && !cyc) begin
      cyc_n = 1'b1;
    end else if (cyc && bus.bus_ack_i) begin
      cyc_n = 1'b0;
      state_n = (state == BUS1 && kind == K_EXC) ? BUS2 : IDLE;
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cyc <= 1'b0;
      kind <= K_NONE;
      l <= '0;
    end else begin
      state <= state_n;
      cyc <= cyc_n;
      if (mem_start) begin
        kind <= kind_in;
        l <= {ir_i, pc_i, pc_set_i, result_i, reg_data2_i, reg_write_i, sp_write_i, sp_data_i, halt_i};
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ir_o <= '0;
      pc_o <= '0;
      pc_set_o <= 1'b0;
      result_o <= '0;
      reg_write_o <= '0;
      sp_write_o <= '0;
      sp_data_o <= '0;
      halt_o <= 1'b0;
    end else if (state == IDLE && !mem_start) begin
      ir_o <= ir_i;
      pc_o <= pc_i;
      pc_set_o <= pc_set_i;
      result_o <= result_i;
      reg_write_o <= reg_write_i;
      sp_write_o <= sp_write_i;
      sp_data_o <= sp_data_i;
      halt_o <= halt_i;
    end else if (done) begin
      ir_o <= l.ir;
      pc_o <= jmp ? l.result : (ret || vec) ? rval : l.pc;
      pc_set_o <= jmp || ret || vec || l.pc_set;
      result_o <= (kind == K_LOAD || (kind == K_POP && !ret)) ? rval : l.result;
      reg_write_o <= l.reg_write;
      sp_write_o <= l.sp_write;
      sp_data_o <= (kind == K_LOAD && l.sp_write == 2'd3) ? rval : l.sp_data;
      halt_o <= l.halt;
    end else begin
      ir_o <= '0;
      pc_set_o <= 1'b0;
      reg_write_o <= '0;
      sp_write_o <= '0;
      halt_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bexkat1_memory.sv
// tb_bexkat1_memory: directed checks of the memory stage with a hand-driven Wishbone slave
module tb_bexkat1_memory;
  logic clk = 1'b0, rst = 1'b0;
  logic [63:0] ir_i, ir_o;
  logic [31:0] pc_i, result_i, reg_data2_i, sp_data_i, pc_o, result_o, sp_data_o;
  logic [1:0] reg_write_i, sp_write_i, reg_write_o, sp_write_o;
  logic pc_set_i, exc_i, halt_i, pc_set_o, halt_o, stall_o;
  int errs = 0, checks = 0;
  bexkat1_memory_if bus();
  bexkat1_memory dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .ir_i(ir_i), .pc_i(pc_i), .pc_set_i(pc_set_i), .result_i(result_i), .reg_data2_i(reg_data2_i),
    .reg_write_i(reg_write_i), .sp_write_i(sp_write_i), .sp_data_i(sp_data_i), .exc_i(exc_i),
    .halt_i(halt_i), .ir_o(ir_o), .pc_o(pc_o), .pc_set_o(pc_set_o), .result_o(result_o),
    .reg_write_o(reg_write_o), .sp_write_o(sp_write_o), .sp_data_o(sp_data_o), .halt_o(halt_o),
    .stall_o(stall_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic slot(input logic [63:0] ir, input logic [31:0] pc, input logic [31:0] res,
                      input logic [31:0] d2, input logic [31:0] sp, input logic [1:0] rw,
                      input logic [1:0] sw, input logic exc, input logic halt);
    ir_i = ir; pc_i = pc; pc_set_i = 1'b0; result_i = res; reg_data2_i = d2;
    sp_data_i = sp; reg_write_i = rw; sp_write_i = sw; exc_i = exc; halt_i = halt;
  endtask
  task automatic idle();
    slot(64'h70000000, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    slot(64'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.bus_ack_i = 1'b0;
    bus.bus_dat_i = 32'h0;
    #12;
    chk("rst_stall", stall_o, 0);
    chk("rst_cyc", bus.bus_cyc_o, 0);
    chk("rst_adr", bus.bus_adr_o, 0);
    chk("rst_sel", bus.bus_sel_o, 0);
    chk("rst_ir", ir_o, 0);
    chk("rst_pc", pc_o, 0);
    @(negedge clk) rst = 1'b1;
    // byte store, ack in cycle 2
    slot(64'hB2000000, 0, 32'h1003, 32'h5A, 0, 0, 0, 0, 0);
    #1 chk("st_c0_stall", stall_o, 1);
    chk("st_c0_cyc", bus.bus_cyc_o, 0);
    @(negedge clk); #1;
    chk("st_cyc", bus.bus_cyc_o, 1);
    chk("st_stb", bus.bus_stb_o, 1);
    chk("st_we", bus.bus_we_o, 1);
    chk("st_adr", bus.bus_adr_o, 32'h1000);
    chk("st_sel", bus.bus_sel_o, 4'b0001);
    chk("st_dat", bus.bus_dat_o, 32'h5A5A5A5A);
    chk("st_c1_stall", stall_o, 1);
    chk("st_bubble_ir", ir_o, 0);
    @(negedge clk) bus.bus_ack_i = 1'b1;
    #1 chk("st_ack_stall", stall_o, 0);
    @(negedge clk) bus.bus_ack_i = 1'b0;
    idle();
    #1 chk("st_ret_ir", ir_o, 64'hB2000000);
    chk("st_ret_rw", reg_write_o, 0);
    chk("st_ret_cyc", bus.bus_cyc_o, 0);
    // halfword load, zero wait
    slot(64'hA1000000, 0, 32'h2002, 0, 0, 2'd1, 0, 0, 0);
    bus.bus_dat_i = 32'hAABBCCDD;
    #1 chk("ldh_c0_stall", stall_o, 1);
    @(negedge clk) bus.bus_ack_i = 1'b1;
    #1 chk("ldh_sel", bus.bus_sel_o, 4'b0011);
    chk("ldh_adr", bus.bus_adr_o, 32'h2000);
    chk("ldh_we", bus.bus_we_o, 0);
    chk("ldh_stall", stall_o, 0);
    @(negedge clk) bus.bus_ack_i = 1'b0;
    idle();
    #1 chk("ldh_result", result_o, 32'h0000CCDD);
    chk("ldh_rw", reg_write_o, 1);
    chk("ldh_ir", ir_o, 64'hA1000000);
    // load into SP
    slot(64'hA0F00000, 0, 32'h3000, 0, 32'h1111, 0, 2'd3, 0, 0);
    bus.bus_dat_i = 32'h00007FF0;
    @(negedge clk) bus.bus_ack_i = 1'b1;
    #1 chk("ldsp_adr", bus.bus_adr_o, 32'h3000);
    @(negedge clk) bus.bus_ack_i = 1'b0;
    idle();
    #1 chk("ldsp_spdata", sp_data_o, 32'h00007FF0);
    chk("ldsp_spw", sp_write_o, 2'd3);
    // interrupt: push pc, gap, vector read
    slot(64'h70000000, 32'h400, 32'hFFFFFFC8, 0, 32'hFFC, 0, 0, 1, 0);
    #1 chk("exc_c0_stall", stall_o, 1);
    @(negedge clk) bus.bus_ack_i = 1'b1;
    #1 chk("exc_w_we", bus.bus_we_o, 1);
    chk("exc_w_adr", bus.bus_adr_o, 32'hFFC);
    chk("exc_w_dat", bus.bus_dat_o, 32'h400);
    chk("exc_w_sel", bus.bus_sel_o, 4'hF);
    chk("exc_c1_stall", stall_o, 1);
    @(negedge clk) bus.bus_ack_i = 1'b0;
    #1 chk("exc_gap_cyc", bus.bus_cyc_o, 0);
    chk("exc_gap_stall", stall_o, 1);
    chk("exc_gap_ir", ir_o, 0);
    chk("exc_gap_pcset", pc_set_o, 0);
    @(negedge clk) bus.bus_ack_i = 1'b1;
    bus.bus_dat_i = 32'h8000;
    #1 chk("exc_r_cyc", bus.bus_cyc_o, 1);
    chk("exc_r_we", bus.bus_we_o, 0);
    chk("exc_r_adr", bus.bus_adr_o, 32'hFFFFFFC8);
    chk("exc_r_stall", stall_o, 0);
    @(negedge clk) bus.bus_ack_i = 1'b0;
    idle();
    #1 chk("exc_pc", pc_o, 32'h8000);
    chk("exc_pcset", pc_set_o, 1);
    // rts
    slot(64'h21000000, 32'h500, 0, 0, 32'h1000, 0, 0, 0, 0);
    @(negedge clk) bus.bus_ack_i = 1'b1;
    bus.bus_dat_i = 32'h1234;
    #1 chk("rts_adr", bus.bus_adr_o, 32'hFFC);
    chk("rts_we", bus.bus_we_o, 0);
    @(negedge clk) bus.bus_ack_i = 1'b0;
    idle();
    #1 chk("rts_pc", pc_o, 32'h1234);
    chk("rts_pcset", pc_set_o, 1);
    // jsr
    slot(64'h11000000, 32'h600, 32'h9000, 32'hBAD, 32'h1FFC, 0, 0, 0, 0);
    @(negedge clk) bus.bus_ack_i = 1'b1;
    #1 chk("jsr_dat", bus.bus_dat_o, 32'h600);
    chk("jsr_adr", bus.bus_adr_o, 32'h1FFC);
    chk("jsr_we", bus.bus_we_o, 1);
    @(negedge clk) bus.bus_ack_i = 1'b0;
    idle();
    #1 chk("jsr_pc", pc_o, 32'h9000);
    chk("jsr_pcset", pc_set_o, 1);
    // reset vector fetch
    slot(64'h05000000, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    #1 chk("rv_c0_stall", stall_o, 1);
    @(negedge clk) bus.bus_ack_i = 1'b1;
    bus.bus_dat_i = 32'h200;
    #1 chk("rv_adr", bus.bus_adr_o, 32'h10);
    chk("rv_we", bus.bus_we_o, 0);
    chk("rv_cyc", bus.bus_cyc_o, 1);
    chk("rv_stall", stall_o, 0);
    @(negedge clk) bus.bus_ack_i = 1'b0;
    idle();
    #1 chk("rv_pc", pc_o, 32'h200);
    // non-memory pass-through
    slot(64'h70000000, 0, 32'hDEAD, 0, 0, 2'd1, 0, 0, 1);
    #1 chk("pt_stall", stall_o, 0);
    chk("pt_cyc", bus.bus_cyc_o, 0);
    @(negedge clk) idle();
    #1 chk("pt_result", result_o, 32'hDEAD);
    chk("pt_halt", halt_o, 1);
    chk("pt_rw", reg_write_o, 1);
    chk("pt_ir", ir_o, 64'h70000000);
    // reset while a load waits for ack
    slot(64'hA0000000, 0, 32'h4000, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("mr_cyc_before", bus.bus_cyc_o, 1);
    #1 rst = 1'b0;
    #1 chk("mr_cyc_async", bus.bus_cyc_o, 0);
    chk("mr_stall", stall_o, 0);
    @(negedge clk) rst = 1'b1;
    slot(64'h70000000, 0, 32'h77, 0, 0, 0, 0, 0, 0);
    #1 chk("mr_ir", ir_o, 0);
    chk("mr_result", result_o, 0);
    chk("mr_cyc", bus.bus_cyc_o, 0);
    chk("mr_stall_after", stall_o, 0);
    @(negedge clk); #1;
    chk("mr_pt_result", result_o, 32'h77);
    chk("mr_pt_ir", ir_o, 64'h70000000);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
